// File: rtl/wb_defs_pkg.sv
// Shared Wishbone definitions: bridge FSM encodings, error read data default,
// and the slave address map used by the interconnect.
package wb_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

  localparam logic [31:0] WB_ERR_RDATA = 32'hDEAD_BEEF;
  localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

  // Slave address map, decoded on the top nibble by the interconnect
  localparam logic [31:0] WB_SLV_MASK     = 32'hF000_0000;
  localparam logic [31:0] WB_SLV_RAM_BASE = 32'h8000_0000;
  localparam logic [31:0] WB_SLV_IO_BASE  = 32'h9000_0000;

  function automatic logic [3:0] wb_sel_from_wstrb(input logic [3:0] wstrb);
    return (|wstrb) ? wstrb : 4'hF;
  endfunction

endpackage

// File: rtl/wb_bus_timeout.sv
// Loadable down-counter: start loads the budget, enable counts it down, and
// expire flags the last permitted cycle so the bridge can finish the access.
module wb_bus_timeout #(
  parameter int unsigned LOAD_VALUE = 255
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [7:0] LOAD = LOAD_VALUE[7:0];

  logic [7:0] count;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      count <= 8'd0;
    end else if (i_start) begin
      count <= LOAD;
    end else if (i_clear) begin
      count <= 8'd0;
    end else if (i_enable && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign o_expire = i_enable && (count == 8'd1);

endmodule

// File: rtl/picorv32_wb_master.sv
// picorv32 native memory bus to pipelined Wishbone master bridge.
// Optional bus timeout is built when WB_BRIDGE_TIMEOUT_EN is defined.
module picorv32_wb_master
  import wb_defs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_RDATA      = WB_ERR_RDATA
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_mem_valid,
  input  logic        i_mem_instr,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_rdata,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic        o_bus_err,
  output logic [31:0] o_bus_err_addr,
  output logic        o_bus_err_instr,
  input  logic        i_err_clr
);

  wb_state_e state, state_next;
  logic      accept;
  logic      complete_ok;
  logic      complete_err;
  logic      timeout_expire;
  logic      req_instr;

`ifdef WB_BRIDGE_TIMEOUT_EN
  wb_bus_timeout #(
    .LOAD_VALUE(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_resetn(i_resetn),
    .i_start (accept),
    .i_clear (state == ST_DONE),
    .i_enable(state == ST_WAIT),
    .o_expire(timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Error beats ack whenever both are seen; a completing access always goes
  // through DONE so the CPU gets exactly one ready pulse.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    complete_ok  = 1'b0;
    complete_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_mem_valid) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!i_wb_stall) begin
          accept = 1'b1;
          if (i_wb_err) begin
            complete_err = 1'b1;
          end else if (i_wb_ack) begin
            complete_ok = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_wb_err || timeout_expire) begin
          complete_err = 1'b1;
        end else if (i_wb_ack) begin
          complete_ok = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (complete_ok || complete_err) begin
      state_next = ST_DONE;
    end
  end

  assign o_wb_cyc    = (state == ST_REQ) || (state == ST_WAIT);
  assign o_wb_stb    = (state == ST_REQ);
  assign o_mem_ready = (state == ST_DONE);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_wb_addr <= 32'h0;
      o_wb_data <= 32'h0;
      o_wb_sel  <= 4'h0;
      o_wb_we   <= 1'b0;
      req_instr <= 1'b0;
    end else if ((state == ST_IDLE) && i_mem_valid) begin
      o_wb_addr <= i_mem_addr;
      o_wb_data <= i_mem_wdata;
      o_wb_sel  <= wb_sel_from_wstrb(i_mem_wstrb);
      o_wb_we   <= |i_mem_wstrb;
      req_instr <= i_mem_instr;
    end
  end

  // Successful writes leave the last read data in place
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_mem_rdata <= 32'h0;
    end else if (complete_err) begin
      o_mem_rdata <= ERR_RDATA;
    end else if (complete_ok && !o_wb_we) begin
      o_mem_rdata <= i_wb_data;
    end
  end

  // A new error outranks a simultaneous clear; the address is only captured
  // for the first error after the flag was last cleared.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_bus_err       <= 1'b0;
      o_bus_err_addr  <= 32'h0;
      o_bus_err_instr <= 1'b0;
    end else if (complete_err) begin
      o_bus_err <= 1'b1;
      if (!o_bus_err) begin
        o_bus_err_addr  <= o_wb_addr;
        o_bus_err_instr <= req_instr;
      end
    end else if (i_err_clr) begin
      o_bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_picorv32_wb_master.sv
// Self-checking bench for picorv32_wb_master: table of single accesses plus
// hand-built sequences for accept-edge ack, err/ack collision, timeout, reset.
module tb_picorv32_wb_master;
  import wb_defs_pkg::*;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        i_clk;
  logic        i_resetn;
  logic        i_mem_valid;
  logic        i_mem_instr;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [3:0]  i_mem_wstrb;
  logic        o_mem_ready;
  logic [31:0] o_mem_rdata;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;
  logic        o_bus_err;
  logic [31:0] o_bus_err_addr;
  logic        o_bus_err_instr;
  logic        i_err_clr;

  picorv32_wb_master #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .i_clk          (i_clk),
    .i_resetn       (i_resetn),
    .i_mem_valid    (i_mem_valid),
    .i_mem_instr    (i_mem_instr),
    .i_mem_addr     (i_mem_addr),
    .i_mem_wdata    (i_mem_wdata),
    .i_mem_wstrb    (i_mem_wstrb),
    .o_mem_ready    (o_mem_ready),
    .o_mem_rdata    (o_mem_rdata),
    .o_wb_addr      (o_wb_addr),
    .o_wb_data      (o_wb_data),
    .o_wb_sel       (o_wb_sel),
    .o_wb_we        (o_wb_we),
    .o_wb_cyc       (o_wb_cyc),
    .o_wb_stb       (o_wb_stb),
    .i_wb_ack       (i_wb_ack),
    .i_wb_err       (i_wb_err),
    .i_wb_stall     (i_wb_stall),
    .i_wb_data      (i_wb_data),
    .o_bus_err      (o_bus_err),
    .o_bus_err_addr (o_bus_err_addr),
    .o_bus_err_instr(o_bus_err_instr),
    .i_err_clr      (i_err_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          stall;
    int          delay;
    bit          use_err;
    logic [31:0] rsp;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_err_addr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  vec_t vecs[8];
  exp_t expQ[$];
  int   checks = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Pops the oldest expected completion and compares it against the DUT
  task automatic checkResponse(input string name);
    exp_t e;
    checkOutput({name, "_ready"}, {31'h0, o_mem_ready}, 32'h1);
    if (expQ.size() == 0) begin
      checkOutput({name, "_sb_empty"}, 32'h1, 32'h0);
      return;
    end
    e = expQ.pop_front();
    checkOutput({name, "_rdata"}, o_mem_rdata, e.rdata);
    checkOutput({name, "_bus_err"}, {31'h0, o_bus_err}, {31'h0, e.err});
    checkOutput({name, "_err_addr"}, o_bus_err_addr, e.err_addr);
  endtask

  task automatic driveRequest(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr);
    @(negedge i_clk);
    i_mem_valid = 1'b1;
    i_mem_instr = instr;
    i_mem_addr  = addr;
    i_mem_wdata = wdata;
    i_mem_wstrb = wstrb;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int    stb_cnt;
    string n;
    n = $sformatf("v%0d", idx);
    driveRequest(v.addr, v.wdata, v.wstrb, 1'b0);
    expQ.push_back('{rdata: v.exp_rdata, err: v.exp_err, err_addr: v.exp_err_addr});
    @(negedge i_clk);
    checkOutput({n, "_addr"}, o_wb_addr, v.addr);
    checkOutput({n, "_sel"}, {28'h0, o_wb_sel}, {28'h0, v.exp_sel});
    checkOutput({n, "_we"}, {31'h0, o_wb_we}, {31'h0, v.exp_we});
    if (v.exp_we) checkOutput({n, "_wdata"}, o_wb_data, v.wdata);
    stb_cnt = 0;
    for (int k = 0; k <= v.stall; k++) begin
      if (o_wb_stb) stb_cnt++;
      i_wb_stall = (k < v.stall);
      @(negedge i_clk);
    end
    i_wb_stall = 1'b0;
    checkOutput({n, "_stb_cycles"}, stb_cnt, v.stall + 1);
    checkOutput({n, "_wait_cyc_stb"}, {30'h0, o_wb_cyc, o_wb_stb}, 32'h2);
    for (int w = 0; w < v.delay; w++) @(negedge i_clk);
    checkOutput({n, "_ready_early"}, {31'h0, o_mem_ready}, 32'h0);
    if (v.use_err) i_wb_err = 1'b1;
    else i_wb_ack = 1'b1;
    i_wb_data = v.rsp;
    @(negedge i_clk);
    i_wb_ack    = 1'b0;
    i_wb_err    = 1'b0;
    i_wb_data   = 32'h5A5A_5A5A;
    i_mem_valid = 1'b0;
    checkResponse(n);
    @(negedge i_clk);
    checkOutput({n, "_one_pulse"}, {30'h0, o_mem_ready, o_wb_cyc}, 32'h0);
  endtask

  initial begin
    int  cyc_n;
    bit  seen_ready;
    bit  cyc_dropped;

    i_resetn    = 1'b0;
    i_mem_valid = 1'b0;
    i_mem_instr = 1'b0;
    i_mem_addr  = 32'h0;
    i_mem_wdata = 32'h0;
    i_mem_wstrb = 4'h0;
    i_wb_ack    = 1'b0;
    i_wb_err    = 1'b0;
    i_wb_stall  = 1'b0;
    i_wb_data   = 32'h0;
    i_err_clr   = 1'b0;

    vecs[0] = '{addr: 32'h8000_0010, wdata: 32'h0, wstrb: 4'h0, stall: 0, delay: 1, use_err: 0,
                rsp: 32'h1234_5678, exp_sel: 4'hF, exp_we: 0, exp_rdata: 32'h1234_5678,
                exp_err: 0, exp_err_addr: 32'h0};
    vecs[1] = '{addr: 32'h8000_0000, wdata: 32'h0000_002A, wstrb: 4'b0001, stall: 3, delay: 1,
                use_err: 0, rsp: 32'hFFFF_FFFF, exp_sel: 4'b0001, exp_we: 1,
                exp_rdata: 32'h1234_5678, exp_err: 0, exp_err_addr: 32'h0};
    vecs[2] = '{addr: 32'h8000_0020, wdata: 32'h0, wstrb: 4'h0, stall: 1, delay: 3, use_err: 0,
                rsp: 32'hCAFE_F00D, exp_sel: 4'hF, exp_we: 0, exp_rdata: 32'hCAFE_F00D,
                exp_err: 0, exp_err_addr: 32'h0};
    vecs[3] = '{addr: 32'h8000_0004, wdata: 32'hAABB_CCDD, wstrb: 4'b1100, stall: 0, delay: 2,
                use_err: 0, rsp: 32'h0BAD_0BAD, exp_sel: 4'b1100, exp_we: 1,
                exp_rdata: 32'hCAFE_F00D, exp_err: 0, exp_err_addr: 32'h0};
    vecs[4] = '{addr: 32'h9000_0000, wdata: 32'h0, wstrb: 4'h0, stall: 0, delay: 1, use_err: 1,
                rsp: 32'h1111_1111, exp_sel: 4'hF, exp_we: 0, exp_rdata: 32'hDEAD_BEEF,
                exp_err: 1, exp_err_addr: 32'h9000_0000};
    vecs[5] = '{addr: 32'h9000_0004, wdata: 32'h0, wstrb: 4'h0, stall: 2, delay: 1, use_err: 1,
                rsp: 32'h2222_2222, exp_sel: 4'hF, exp_we: 0, exp_rdata: 32'hDEAD_BEEF,
                exp_err: 1, exp_err_addr: 32'h9000_0000};
    vecs[6] = '{addr: 32'h8000_0030, wdata: 32'h0, wstrb: 4'h0, stall: 0, delay: 0, use_err: 0,
                rsp: 32'h0000_0000, exp_sel: 4'hF, exp_we: 0, exp_rdata: 32'h0000_0000,
                exp_err: 1, exp_err_addr: 32'h9000_0000};
    vecs[7] = '{addr: 32'h8000_0008, wdata: 32'h1122_3344, wstrb: 4'hF, stall: 0, delay: 1,
                use_err: 0, rsp: 32'hFFFF_FFFF, exp_sel: 4'hF, exp_we: 1,
                exp_rdata: 32'h0000_0000, exp_err: 1, exp_err_addr: 32'h9000_0000};

    #1;
    checkOutput("reset_outputs",
                {28'h0, o_mem_ready, o_wb_cyc, o_wb_stb, o_bus_err}, 32'h0);
    checkOutput("reset_rdata", o_mem_rdata, 32'h0);
    checkOutput("reset_err_addr", o_bus_err_addr, 32'h0);
    repeat (2) @(negedge i_clk);
    i_resetn = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Ack sampled on the same edge that accepts the strobe
    driveRequest(32'h8000_0040, 32'h0, 4'h0, 1'b0);
    expQ.push_back('{rdata: 32'h5555_AAAA, err: 1'b1, err_addr: 32'h9000_0000});
    @(negedge i_clk);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h5555_AAAA;
    @(negedge i_clk);
    i_wb_ack    = 1'b0;
    i_mem_valid = 1'b0;
    checkResponse("accept_ack");

    // Clear the sticky flag; the recorded address is left alone
    @(negedge i_clk);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    checkOutput("err_clr_flag", {31'h0, o_bus_err}, 32'h0);
    checkOutput("err_clr_addr", o_bus_err_addr, 32'h9000_0000);

    // Ack and err together, with a clear in the same cycle
    driveRequest(32'h9000_0100, 32'h0, 4'h0, 1'b1);
    expQ.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1, err_addr: 32'h9000_0100});
    @(negedge i_clk);
    @(negedge i_clk);
    i_wb_ack  = 1'b1;
    i_wb_err  = 1'b1;
    i_err_clr = 1'b1;
    i_wb_data = 32'h7777_7777;
    @(negedge i_clk);
    i_wb_ack    = 1'b0;
    i_wb_err    = 1'b0;
    i_err_clr   = 1'b0;
    i_mem_valid = 1'b0;
    checkResponse("ack_err_clr");
    checkOutput("ack_err_instr", {31'h0, o_bus_err_instr}, 32'h1);
    @(negedge i_clk);
    checkOutput("ack_err_sticky", {31'h0, o_bus_err}, 32'h1);

    // Slave never answers
    driveRequest(32'h9000_0200, 32'h0, 4'h0, 1'b0);
`ifdef WB_BRIDGE_TIMEOUT_EN
    expQ.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1, err_addr: 32'h9000_0100});
`else
    expQ.push_back('{rdata: 32'h0BAD_F00D, err: 1'b1, err_addr: 32'h9000_0100});
`endif
    @(negedge i_clk);
    cyc_n       = 1;
    seen_ready  = 0;
    cyc_dropped = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      cyc_n++;
      if (o_mem_ready) begin
        seen_ready = 1;
        break;
      end
      if (!o_wb_cyc) cyc_dropped = 1;
    end
`ifdef WB_BRIDGE_TIMEOUT_EN
    i_mem_valid = 1'b0;
    checkOutput("tmo_seen", {31'h0, seen_ready}, 32'h1);
    checkOutput("tmo_latency", cyc_n, 10);
    checkResponse("tmo");
`else
    checkOutput("no_tmo_ready", {31'h0, seen_ready}, 32'h0);
    checkOutput("no_tmo_cyc", {30'h0, cyc_dropped, o_wb_cyc}, 32'h1);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h0BAD_F00D;
    @(negedge i_clk);
    i_wb_ack    = 1'b0;
    i_mem_valid = 1'b0;
    checkResponse("late_ack");
`endif
    @(negedge i_clk);

    // Reset while waiting for the slave
    driveRequest(32'h8000_0050, 32'h0, 4'h0, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_resetn    = 1'b0;
    i_mem_valid = 1'b0;
    #1;
    checkOutput("rst_wait_ctrl", {29'h0, o_wb_cyc, o_wb_stb, o_mem_ready}, 32'h0);
    checkOutput("rst_wait_err", {31'h0, o_bus_err}, 32'h0);
    checkOutput("rst_wait_rdata", o_mem_rdata, 32'h0);
    @(negedge i_clk);
    i_resetn  = 1'b1;
    @(negedge i_clk);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hBADB_AD00;
    @(negedge i_clk);
    i_wb_ack  = 1'b0;
    checkOutput("stale_ack", {30'h0, o_mem_ready, o_wb_cyc}, 32'h0);
    applyStimulus('{addr: 32'h8000_0060, wdata: 32'h0, wstrb: 4'h0, stall: 0, delay: 1,
                    use_err: 0, rsp: 32'h600D_CAFE, exp_sel: 4'hF, exp_we: 0,
                    exp_rdata: 32'h600D_CAFE, exp_err: 0, exp_err_addr: 32'h0}, 99);

    checkOutput("sb_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
